req_gnt_initiator: RTL and testbench



---
 rtl/req_gnt_pkg.sv | 13 +
 rtl/req_gnt_initiator_sva.sv | 53 +++++
 rtl/req_gnt_initiator.sv | 116 +++++++++++
 tb/tb_req_gnt_initiator.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/req_gnt_pkg.sv
// Shared types and default window/retry limits for the req/gnt handshake blocks.
package req_gnt_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    BACKOFF = 2'd2
  } req_gnt_state_e;

  localparam int REQ_GNT_MAX_WAIT  = 2;
  localparam int REQ_GNT_MAX_RETRY = 3;

endpackage

// File: rtl/req_gnt_initiator_sva.sv
// Window-protocol checker for a req/gnt initiator; bound into req_gnt_initiator below.
module req_gnt_initiator_sva #(
  parameter int MAX_WAIT = 2
) (
  input logic i_clk,
  input logic i_rst_n,
  input logic i_req,
  input logic i_gnt,
  input logic i_busy,
  input logic i_done,
  input logic i_timeout_err
);

  // Number of consecutive earlier samples with req high (the current window index).
  int r_run;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run <= 0;
    end else if (!i_req) begin
      r_run <= 0;
    end else if (r_run <= MAX_WAIT) begin
      r_run <= r_run + 1;
    end
  end

  // req must be released no later than the sample after window index MAX_WAIT.
  a_req_window: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_req |-> (r_run <= MAX_WAIT));

  a_gnt_releases_req: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (i_req && i_gnt && (r_run != 0)) |=> !i_req);

  a_done_after_gnt: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_done |-> $past(i_gnt));

  a_done_timeout_excl: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_done && i_timeout_err));

  a_req_implies_busy: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_req && !i_busy));

endmodule

bind req_gnt_initiator req_gnt_initiator_sva #(.MAX_WAIT(MAX_WAIT)) u_sva (
  .i_clk         (i_clk),
  .i_rst_n       (i_rst_n),
  .i_req         (o_req),
  .i_gnt         (i_gnt),
  .i_busy        (o_busy),
  .i_done        (o_done),
  .i_timeout_err (o_timeout_err)
);

// File: rtl/req_gnt_initiator.sv
// Requester side of the req/gnt handshake: bounded grant window, retries, latency report.
//
// state   | meaning
// IDLE    | no transaction; start accepted here
// REQ     | req high, counting window index k = wait_cnt
// BACKOFF | one cycle with req low between attempts
module req_gnt_initiator
  import req_gnt_pkg::*;
#(
  parameter int MAX_WAIT  = REQ_GNT_MAX_WAIT,
  parameter int MAX_RETRY = REQ_GNT_MAX_RETRY,
  parameter int LAT_W     = $clog2(MAX_WAIT + 1),
  parameter int RTY_W     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_gnt,
  output logic             o_req,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_timeout_err,
  output logic [LAT_W-1:0] o_latency,
  output logic [RTY_W-1:0] o_retry_cnt
);

  localparam logic [LAT_W-1:0] C_MAX_WAIT  = LAT_W'(MAX_WAIT);
  localparam logic [RTY_W-1:0] C_MAX_RETRY = RTY_W'(MAX_RETRY);

  req_gnt_state_e   r_state, w_state;
  logic             r_req, w_req;
  logic             r_done, w_done;
  logic             r_timeout, w_timeout;
  logic [LAT_W-1:0] r_wait_cnt, w_wait_cnt;
  logic [LAT_W-1:0] r_latency, w_latency;
  logic [RTY_W-1:0] r_retry_cnt, w_retry_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_req       <= 1'b0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_wait_cnt  <= '0;
      r_latency   <= '0;
      r_retry_cnt <= '0;
    end else begin
      r_state     <= w_state;
      r_req       <= w_req;
      r_done      <= w_done;
      r_timeout   <= w_timeout;
      r_wait_cnt  <= w_wait_cnt;
      r_latency   <= w_latency;
      r_retry_cnt <= w_retry_cnt;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_req       = r_req;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    w_wait_cnt  = r_wait_cnt;
    w_latency   = r_latency;
    w_retry_cnt = r_retry_cnt;
    case (r_state)
      IDLE: begin
        w_req = 1'b0;
        if (i_start) begin
          w_req       = 1'b1;
          w_wait_cnt  = '0;
          w_retry_cnt = '0;
          w_state     = REQ;
        end
      end
      REQ: begin
        w_req = 1'b1;
        // A grant at k=0 belongs to a previous request and is not accepted.
        if (i_gnt && (r_wait_cnt != '0)) begin
          w_done    = 1'b1;
          w_latency = r_wait_cnt;
          w_req     = 1'b0;
          w_state   = IDLE;
        end else if (r_wait_cnt == C_MAX_WAIT) begin
          w_req = 1'b0;
          if (r_retry_cnt < C_MAX_RETRY) begin
            w_retry_cnt = r_retry_cnt + RTY_W'(1);
            w_state     = BACKOFF;
          end else begin
            w_timeout = 1'b1;
            w_state   = IDLE;
          end
        end else begin
          w_wait_cnt = r_wait_cnt + LAT_W'(1);
        end
      end
      BACKOFF: begin
        w_req      = 1'b1;
        w_wait_cnt = '0;
        w_state    = REQ;
      end
      default: begin
        w_req   = 1'b0;
        w_state = IDLE;
      end
    endcase
  end

  assign o_req         = r_req;
  assign o_busy        = (r_state != IDLE);
  assign o_done        = r_done;
  assign o_timeout_err = r_timeout;
  assign o_latency     = r_latency;
  assign o_retry_cnt   = r_retry_cnt;

endmodule

// File: tb/tb_req_gnt_initiator.sv
// Vector-table bench for req_gnt_initiator with a scoreboard of expected completions.
module tb_req_gnt_initiator;

  localparam int LAT_W  = 2;
  localparam int RTY_W  = 2;
  localparam int BUDGET = 24;

  logic             i_clk;
  logic             i_rst_n;
  logic             i_start;
  logic             i_gnt;
  logic             o_req;
  logic             o_busy;
  logic             o_done;
  logic             o_timeout_err;
  logic [LAT_W-1:0] o_latency;
  logic [RTY_W-1:0] o_retry_cnt;

  req_gnt_initiator dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_start       (i_start),
    .i_gnt         (i_gnt),
    .o_req         (o_req),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_timeout_err (o_timeout_err),
    .o_latency     (o_latency),
    .o_retry_cnt   (o_retry_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // gnt_mask bit n drives gnt into edge n, where edge 0 is the edge sampling start.
  typedef struct {
    string       name;
    logic [31:0] gnt_mask;
    int          extra_start;
    int          exp_cycle;
    bit          exp_done;
    int          exp_lat;
    int          exp_rty;
  } vec_t;

  typedef struct {
    int cycle;
    bit done;
    int lat;
    int rty;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input bit push);
    exp_t e;
    bit   seen;
    seen = 1'b0;
    if (push) sb_q.push_back('{v.exp_cycle, v.exp_done, v.exp_lat, v.exp_rty});
    for (int n = 0; n < BUDGET && !seen; n++) begin
      i_start = (n == 0) || (n == v.extra_start);
      i_gnt   = v.gnt_mask[n];
      @(posedge i_clk);
      @(negedge i_clk);
      if (n == 0) begin
        chk({v.name, " req_after_start"}, int'(o_req), 1);
        chk({v.name, " busy_after_start"}, int'(o_busy), 1);
      end
      if (o_done || o_timeout_err) begin
        seen = 1'b1;
        if (sb_q.size() == 0) begin
          chk({v.name, " unexpected_pulse"}, 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk({v.name, " pulse_cycle"}, n, e.cycle);
          chk({v.name, " done"}, int'(o_done), int'(e.done));
          chk({v.name, " timeout_err"}, int'(o_timeout_err), int'(!e.done));
          if (e.done) chk({v.name, " latency"}, int'(o_latency), e.lat);
          chk({v.name, " retry_cnt"}, int'(o_retry_cnt), e.rty);
          chk({v.name, " req_low_at_pulse"}, int'(o_req), 0);
          chk({v.name, " busy_low_at_pulse"}, int'(o_busy), 0);
        end
      end
    end
    i_start = 1'b0;
    i_gnt   = 1'b0;
    if (!seen) chk({v.name, " pulse_within_budget"}, 0, 1);
  endtask

  task automatic idle_watch(input string name, input int cycles);
    int pulses;
    pulses = 0;
    for (int n = 0; n < cycles; n++) begin
      i_gnt = n[0];
      @(posedge i_clk);
      @(negedge i_clk);
      if (o_done || o_timeout_err || o_req || o_busy) pulses++;
    end
    i_gnt = 1'b0;
    chk({name, " idle_activity"}, pulses, 0);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{"k1_idle_gnt",   32'h0000_0005, -1,  2, 1'b1, 1, 0};
    vecs[1] = '{"k2",            32'h0000_0008, -1,  3, 1'b1, 2, 0};
    vecs[2] = '{"no_gnt",        32'h0000_0000, -1, 15, 1'b0, 0, 3};
    vecs[3] = '{"att2_k1",       32'h0000_0400, -1, 10, 1'b1, 1, 2};
    vecs[4] = '{"stale_k0",      32'h0000_000A,  2,  3, 1'b1, 2, 0};
    vecs[5] = '{"stale_all",     32'h0000_2222,  8, 15, 1'b0, 0, 3};
    vecs[6] = '{"backoff_gnt",   32'h0000_0050, -1,  6, 1'b1, 1, 1};
    vecs[7] = '{"last_window",   32'h0000_8000, -1, 15, 1'b1, 2, 3};
    vecs[8] = '{"gnt_held",      32'h0000_000C, -1,  2, 1'b1, 1, 0};

    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_gnt   = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("rst req", int'(o_req), 0);
    chk("rst busy", int'(o_busy), 0);
    chk("rst done", int'(o_done), 0);
    chk("rst timeout_err", int'(o_timeout_err), 0);
    chk("rst latency", int'(o_latency), 0);
    chk("rst retry_cnt", int'(o_retry_cnt), 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    idle_watch("gnt_in_idle", 6);

    // Back-to-back: each vector starts the cycle after the previous pulse.
    for (int i = 0; i < 9; i++) run_vec(vecs[i], 1'b1);
    idle_watch("after_vectors", 20);

    // Reset mid-retry: start, no grant, pull reset during attempt 1 just before k=1.
    i_start = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      i_start = 1'b0;
    end
    chk("pre_rst req", int'(o_req), 1);
    chk("pre_rst retry_cnt", int'(o_retry_cnt), 1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("async_rst req", int'(o_req), 0);
    chk("async_rst busy", int'(o_busy), 0);
    chk("async_rst retry_cnt", int'(o_retry_cnt), 0);
    chk("async_rst latency", int'(o_latency), 0);
    begin
      int pulses;
      pulses = 0;
      repeat (3) begin
        @(negedge i_clk);
        if (o_done || o_timeout_err) pulses++;
      end
      chk("in_rst pulses", pulses, 0);
    end
    i_rst_n = 1'b1;
    idle_watch("after_rst", 4);
    run_vec('{"post_rst_k2", 32'h0000_0008, -1, 3, 1'b1, 2, 0}, 1'b1);
    idle_watch("final", 5);

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
